// File: rtl/audio_pkg.sv
// audio_pkg
// Shared definitions for the PDM playback path: buffer geometry defaults,
// the buffer address width and the playback FSM state type.
package audio_pkg;

    localparam int MEM_WIDTH_DEF = 16;
    localparam int MEM_DEPTH_DEF = 65536;
    localparam int ADDR_W_DEF    = $clog2(MEM_DEPTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } pb_state_e;

endpackage

// File: rtl/pdm_bit_timer.sv
// pdm_bit_timer
// Bit-rate divider for the PDM serializer. Counts 0..CLK_DIV-1 and wraps,
// pulsing bit_tick on the terminal count. start restarts the count at 0 so
// the first bit of a playback is held for a full CLK_DIV period.
//
// Ports:
//   clk      in   system clock
//   resetn   in   asynchronous active-low reset
//   start    in   restart the bit period
//   bit_tick out  one-cycle pulse every CLK_DIV cycles
module pdm_bit_timer
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    output logic bit_tick
);

    localparam int              CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] TC   = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign bit_tick = (count_q == TC);

    always_comb begin
        count_d = count_q + 1'b1;
        if (start || bit_tick) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pdm_playback.sv
// pdm_playback
// Streams buffer words out as a serial PDM bit stream, LSB first, one bit
// every CLK_DIV clocks. The first word is read in PRIME and loaded in LOAD;
// every word start then prefetches the following word so the word boundary
// has neither gap nor repeat.
//
// Build option: define PDM_PLAYBACK_LOOP_EN to let sw[1] wrap playback from
// the last buffer word back to word 0. Without it sw[1] is ignored and every
// playback ends at the last word with a done pulse.
//
// Ports:
//   clk           in   system clock
//   resetn        in   asynchronous active-low reset
//   sw[1:0]       in   sw[0] play, sw[1] loop
//   read_address  out  buffer port-B address
//   read_enable   out  buffer port-B read strobe (one cycle per word)
//   read_data     in   buffer port-B data, valid 1 clk after read_enable
//   pdm_out       out  serial PDM bit
//   audio_sd      out  amplifier enable (equals busy)
//   busy          out  playback active
//   done          out  one-cycle pulse at end of a non-looping playback
module pdm_playback
    import audio_pkg::*;
#(
    parameter int MEM_WIDTH = MEM_WIDTH_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int CLK_DIV   = 50
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            sw,
    output logic [ADDR_W_DEF-1:0] read_address,
    output logic                  read_enable,
    input  logic [MEM_WIDTH-1:0]  read_data,
    output logic                  pdm_out,
    output logic                  audio_sd,
    output logic                  busy,
    output logic                  done
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int BIT_W  = (MEM_WIDTH > 1) ? $clog2(MEM_WIDTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(MEM_WIDTH - 1);

    pb_state_e             state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [MEM_WIDTH-1:0]  shift_q, shift_d;
    logic [MEM_WIDTH-1:0]  next_word_q, next_word_d;
    logic [BIT_W-1:0]      bit_idx_q, bit_idx_d;
    logic                  pdm_q, pdm_d;
    logic                  prefetch_q, prefetch_d;
    logic                  capture_q, capture_d;
    logic                  done_q, done_d;
    logic                  eob_q, eob_d;

    logic                  loop_en;
    logic                  timer_start;
    logic                  bit_tick;
    logic                  word_end;
    logic [ADDR_W-1:0]     addr_nxt;
    logic [BIT_W-1:0]      next_idx;

`ifdef PDM_PLAYBACK_LOOP_EN
    assign loop_en = sw[1];
`else
    logic unused_sw1;
    assign unused_sw1 = sw[1];
    assign loop_en    = 1'b0;
`endif

    pdm_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .resetn   (resetn),
        .start    (timer_start),
        .bit_tick (bit_tick)
    );

    assign addr_nxt = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    assign next_idx = bit_idx_q + 1'b1;
    assign word_end = bit_tick && (bit_idx_q == LAST_BIT);

    // addr_q tracks the word being played; the prefetch cycle drives the
    // address of the word after it.
    assign read_address = ADDR_W_DEF'(prefetch_q ? addr_nxt : addr_q);
    assign read_enable  = (state_q == ST_PRIME) || prefetch_q;
    assign busy         = (state_q != ST_IDLE);
    assign audio_sd     = busy;
    assign pdm_out      = pdm_q;
    assign done         = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        shift_d     = shift_q;
        next_word_d = next_word_q;
        bit_idx_d   = bit_idx_q;
        pdm_d       = pdm_q;
        prefetch_d  = 1'b0;
        capture_d   = prefetch_q;
        done_d      = 1'b0;
        eob_d       = eob_q;
        timer_start = 1'b0;

        if (capture_q) begin
            next_word_d = read_data;
        end

        case (state_q)
            ST_IDLE: begin
                pdm_d  = 1'b0;
                addr_d = '0;
                eob_d  = 1'b0;
                if (sw[0]) begin
                    state_d = ST_PRIME;
                end
            end

            ST_PRIME: begin
                state_d = ST_LOAD;
            end

            ST_LOAD: begin
                shift_d     = read_data;
                pdm_d       = read_data[0];
                bit_idx_d   = '0;
                timer_start = 1'b1;
                // A single-word buffer is already on its last word here.
                if ((addr_q == LAST_ADDR) && !loop_en) begin
                    state_d = ST_DRAIN;
                    eob_d   = 1'b1;
                end else begin
                    state_d    = ST_RUN;
                    prefetch_d = 1'b1;
                end
            end

            ST_RUN: begin
                if (word_end) begin
                    if (!sw[0]) begin
                        // Stop seen on the last cycle of a word: it is
                        // already finished, so skip DRAIN.
                        state_d = ST_IDLE;
                        pdm_d   = 1'b0;
                    end else begin
                        shift_d   = next_word_q;
                        pdm_d     = next_word_q[0];
                        bit_idx_d = '0;
                        addr_d    = addr_nxt;
                        // The last word needs no prefetch: play it out in DRAIN.
                        if ((addr_nxt == LAST_ADDR) && !loop_en) begin
                            state_d = ST_DRAIN;
                            eob_d   = 1'b1;
                        end else begin
                            prefetch_d = 1'b1;
                        end
                    end
                end else begin
                    if (bit_tick) begin
                        bit_idx_d = next_idx;
                        pdm_d     = shift_q[next_idx];
                    end
                    if (!sw[0]) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                // sw is deliberately not looked at until IDLE.
                if (word_end) begin
                    state_d = ST_IDLE;
                    pdm_d   = 1'b0;
                    done_d  = eob_q;
                end else if (bit_tick) begin
                    bit_idx_d = next_idx;
                    pdm_d     = shift_q[next_idx];
                end
            end

            default: begin
                state_d = ST_IDLE;
                pdm_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            shift_q     <= '0;
            next_word_q <= '0;
            bit_idx_q   <= '0;
            pdm_q       <= 1'b0;
            prefetch_q  <= 1'b0;
            capture_q   <= 1'b0;
            done_q      <= 1'b0;
            eob_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            shift_q     <= shift_d;
            next_word_q <= next_word_d;
            bit_idx_q   <= bit_idx_d;
            pdm_q       <= pdm_d;
            prefetch_q  <= prefetch_d;
            capture_q   <= capture_d;
            done_q      <= done_d;
            eob_q       <= eob_d;
        end
    end

endmodule

// File: tb/tb_pdm_playback.sv
// tb_pdm_playback
// Bench for pdm_playback with a 4-word buffer and CLK_DIV=4. A cycle-offset
// model predicts busy, pdm_out, read strobes and done from the play start
// cycle; directed literal checks pin the model at chosen points.
module tb_pdm_playback;

    localparam int W        = 16;
    localparam int DEPTH    = 4;
    localparam int DIV      = 4;
    localparam int WORD_CYC = W * DIV;
`ifdef PDM_PLAYBACK_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [1:0]  sw = 2'b00;
    logic [15:0] read_address;
    logic        read_enable;
    logic [15:0] read_data = 16'h0000;
    logic        pdm_out;
    logic        audio_sd;
    logic        busy;
    logic        done;

    logic [15:0] mem [DEPTH] = '{16'hA5A5, 16'h0001, 16'h3C5A, 16'hFFFE};

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int re_count = 0;
    int done_count = 0;

    pdm_playback #(
        .MEM_WIDTH (W),
        .MEM_DEPTH (DEPTH),
        .CLK_DIV   (DIV)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .sw           (sw),
        .read_address (read_address),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .pdm_out      (pdm_out),
        .audio_sd     (audio_sd),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Buffer port B: one-cycle read latency.
    initial forever begin
        @(posedge clk);
        if (read_enable) read_data <= mem[int'(read_address) % DEPTH];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- model + per-cycle compare ----------------
    bit          m_active = 1'b0;
    bit          m_loop = 1'b0;
    bit          m_stopped = 1'b0;
    bit          m_natural = 1'b0;
    int          m_t0 = 0;
    int          m_t_end = -1;
    int          t, rel, n, w;
    logic        e_busy, e_pdm, e_re, e_done;
    logic [15:0] e_addr;

    initial forever begin
        @(negedge clk);
        t = cyc;
        e_busy = 1'b0; e_pdm = 1'b0; e_re = 1'b0; e_done = 1'b0; e_addr = 16'h0;
        if (!resetn) begin
            m_active = 1'b0;
        end else begin
            if (m_active && t == m_t_end) begin
                m_active = 1'b0;
                e_done   = m_natural;
            end
            if (!m_active && sw[0]) begin
                m_active  = 1'b1;
                m_t0      = t;
                m_loop    = LOOP_EN && sw[1];
                m_stopped = 1'b0;
                m_natural = !m_loop;
                m_t_end   = m_loop ? -1 : t + 3 + DEPTH * WORD_CYC;
            end
            if (m_active && t > m_t0) begin
                e_busy = 1'b1;
                if (t == m_t0 + 1) begin
                    e_re = 1'b1;
                    e_addr = 16'h0;
                end
                if (t >= m_t0 + 3) begin
                    rel = t - m_t0 - 3;
                    n   = rel / DIV;
                    w   = n / W;
                    e_pdm = mem[w % DEPTH][n % W];
                    if (rel % WORD_CYC == 0 && (m_loop || w < DEPTH - 1)) begin
                        e_re   = 1'b1;
                        e_addr = 16'((w + 1) % DEPTH);
                    end
                    if (!sw[0] && !m_stopped && (m_loop || w < DEPTH - 1)) begin
                        m_stopped = 1'b1;
                        m_natural = 1'b0;
                        m_t_end   = m_t0 + 3 + (w + 1) * WORD_CYC;
                    end
                end
            end
        end
        check("busy", 32'(busy), 32'(e_busy));
        check("audio_sd", 32'(audio_sd), 32'(e_busy));
        check("pdm_out", 32'(pdm_out), 32'(e_pdm));
        check("read_enable", 32'(read_enable), 32'(e_re));
        check("done", 32'(done), 32'(e_done));
        if (e_re) check("read_address", 32'(read_address), 32'(e_addr));
        if (read_enable) re_count = re_count + 1;
        if (done) done_count = done_count + 1;
    end

    // ---------------- directed stimulus ----------------
    int seq_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int c0, re0, d0;

    initial begin
        resetn = 1'b0;
        sw     = 2'b00;
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;

        // Idle with play off: nothing must move.
        c0 = cyc;
        re0 = re_count;
        wait_until(c0 + 1000);
        check("idle_re_count", 32'(re_count - re0), 32'd0);
        check("idle_audio_sd", 32'(audio_sd), 32'd0);
        check("idle_pdm", 32'(pdm_out), 32'd0);

        // Single non-looping playback of all 4 words.
        c0 = cyc; re0 = re_count; d0 = done_count;
        sw = 2'b01;
        for (int k = 0; k < 8; k++) begin
            wait_until(c0 + 3 + 4 * k);
            check("w0_bit_first", 32'(pdm_out), 32'(seq_a5[k]));
            wait_until(c0 + 3 + 4 * k + 3);
            check("w0_bit_held", 32'(pdm_out), 32'(seq_a5[k]));
        end
        wait_until(c0 + 66);
        check("w0_bit15", 32'(pdm_out), 32'd1);
        wait_until(c0 + 67);
        check("w1_bit0", 32'(pdm_out), 32'd1);
        wait_until(c0 + 71);
        check("w1_bit1", 32'(pdm_out), 32'd0);
        wait_until(c0 + 200);
        sw = 2'b00;
        wait_until(c0 + 258);
        check("end_busy_before", 32'(busy), 32'd1);
        wait_until(c0 + 259);
        check("end_done", 32'(done), 32'd1);
        check("end_busy_after", 32'(busy), 32'd0);
        wait_until(c0 + 300);
        check("play_re_count", 32'(re_count - re0), 32'd4);
        check("play_done_count", 32'(done_count - d0), 32'd1);

        // Loop request.
        c0 = cyc; re0 = re_count; d0 = done_count;
        sw = 2'b11;
`ifdef PDM_PLAYBACK_LOOP_EN
        wait_until(c0 + 3 + 3 * WORD_CYC);
        check("wrap_re", 32'(read_enable), 32'd1);
        check("wrap_addr", 32'(read_address), 32'd0);
        wait_until(c0 + 3 + 5 * WORD_CYC + 20);
        sw = 2'b00;
        wait_until(c0 + 3 + 6 * WORD_CYC + 10);
        check("loop_re_count", 32'(re_count - re0), 32'd7);
        check("loop_done_count", 32'(done_count - d0), 32'd0);
        check("loop_busy", 32'(busy), 32'd0);
`else
        wait_until(c0 + 3 + 3 * WORD_CYC);
        check("noloop_last_re", 32'(read_enable), 32'd0);
        wait_until(c0 + 200);
        sw = 2'b00;
        wait_until(c0 + 300);
        check("noloop_re_count", 32'(re_count - re0), 32'd4);
        check("noloop_done_count", 32'(done_count - d0), 32'd1);
`endif

        // Stop at bit 5 of word 2, re-press during DRAIN.
        c0 = cyc; d0 = done_count;
        sw = 2'b01;
        wait_until(c0 + 152);
        sw = 2'b00;
        wait_until(c0 + 155);
        check("stop_bit6", 32'(pdm_out), 32'd1);
        wait_until(c0 + 160);
        sw = 2'b01;
        wait_until(c0 + 183);
        check("stop_bit13", 32'(pdm_out), 32'd1);
        wait_until(c0 + 194);
        check("stop_busy_before", 32'(busy), 32'd1);
        wait_until(c0 + 195);
        check("stop_busy_after", 32'(busy), 32'd0);
        check("stop_no_done", 32'(done), 32'd0);
        wait_until(c0 + 196);
        check("replay_re", 32'(read_enable), 32'd1);
        check("replay_addr", 32'(read_address), 32'd0);
        check("stop_done_count", 32'(done_count - d0), 32'd0);

        // Reset at bit 9 of the replayed word 0.
        wait_until(c0 + 235);
        check("pre_reset_busy", 32'(busy), 32'd1);
        d0 = done_count;
        resetn = 1'b0;
        sw     = 2'b00;
        #1;
        check("rst_pdm", 32'(pdm_out), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_audio_sd", 32'(audio_sd), 32'd0);
        check("rst_re", 32'(read_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(read_address), 32'd0);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b1;
        c0 = cyc;
        wait_until(c0 + 50);
        check("post_reset_done_count", 32'(done_count - d0), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
